// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Imported by program_loader and word_packer.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        PAYLOAD,
        FLUSH,
        DONE,
        RUN,
        ERROR
    } loader_state_t;

    localparam int unsigned HEADER_LEN             = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/word_packer.sv
// Four-lane byte accumulator: collects bytes little-endian and emits a
// 32-bit word when lane 3 fills or when a flush is requested with a byte.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_in,
    input  logic        flush,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] lanes_q, lanes_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic [31:0] merged;

    // Lanes are zeroed after every emitted word, so a flushed partial word
    // carries zeros in the lanes that never received a byte.
    always_comb begin
        merged                       = lanes_q;
        merged[{lane, 3'b000} +: 8]  = byte_in;
        lanes_d                      = lanes_q;
        word_d                       = word_q;
        valid_d                      = 1'b0;
        if (clear) begin
            lanes_d = '0;
        end else if (byte_valid) begin
            if (lane == 2'd3 || flush) begin
                word_d  = merged;
                valid_d = 1'b1;
                lanes_d = '0;
            end else begin
                lanes_d = merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lanes_q <= lanes_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/program_loader.sv
// Boot controller: parses a length-prefixed image from the UART byte stream,
// writes it to memory as 32-bit words, then gates core start-up.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              start_req,
    input  logic              abort,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_run,
    output logic              core_clear,
    output logic [15:0]       byte_count,
    output logic              error
);

    localparam logic [16:0] MAX_LEN = 17'(4 * (2 ** ADDR_W));

    loader_state_t     state_q, state_d;
    logic              rx_ready_q;
    logic              start_q;
    logic [15:0]       len_q, len_d;
    logic [15:0]       count_q, count_d;
    logic [31:0]       gap_q, gap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              byte_event;
    logic              start_event;
    logic [15:0]       hdr_len;
    logic              len_ok;
    logic              timed_out;
    logic              pk_clear, pk_valid, pk_flush;
    logic              core_clear_c;
    logic [31:0]       pk_word;
    logic              pk_word_valid;

    assign byte_event  = rx_ready & ~rx_ready_q;
    assign start_event = start_req & ~start_q;
    assign hdr_len     = {rx_data, len_q[7:0]};
    assign len_ok      = (hdr_len != 16'd0) && ({1'b0, hdr_len} <= MAX_LEN);
    assign timed_out   = (gap_q >= TIMEOUT_CYCLES);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        count_d      = count_q;
        addr_d       = addr_q;
        gap_d        = 32'd0;
        pk_clear     = 1'b0;
        pk_valid     = 1'b0;
        pk_flush     = 1'b0;
        core_clear_c = 1'b0;

        // The gap counter only runs inside a frame and saturates at all-ones.
        if ((state_q == LEN_HI || state_q == PAYLOAD) && !byte_event && gap_q != '1) begin
            gap_d = gap_q + 32'd1;
        end

        if (abort) begin
            state_d  = IDLE;
            len_d    = '0;
            count_d  = '0;
            pk_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (byte_event) begin
                        len_d    = {8'h00, rx_data};
                        count_d  = '0;
                        pk_clear = 1'b1;
                        state_d  = LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (byte_event) begin
                        len_d   = hdr_len;
                        state_d = len_ok ? PAYLOAD : ERROR;
                    end else if (timed_out) begin
                        state_d = ERROR;
                    end
                end
                PAYLOAD: begin
                    if (byte_event) begin
                        pk_valid = 1'b1;
                        addr_d   = count_q[ADDR_W+1:2];
                        count_d  = count_q + 16'd1;
                        if (count_d == len_q) begin
                            pk_flush = (count_q[1:0] != 2'd3);
                            state_d  = (count_q[1:0] == 2'd3) ? DONE : FLUSH;
                        end
                    end else if (timed_out) begin
                        state_d = ERROR;
                    end
                end
                FLUSH: begin
                    state_d = DONE;
                end
                DONE: begin
                    if (start_event) begin
                        core_clear_c = 1'b1;
                        state_d      = RUN;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                ERROR: begin
                    if (start_event) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Edge registers reset high so levels already asserted at reset are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b1;
            start_q    <= 1'b1;
            len_q      <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready;
            start_q    <= start_req;
            len_q      <= len_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            addr_q     <= addr_d;
        end
    end

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .lane       (count_q[1:0]),
        .byte_in    (rx_data),
        .flush      (pk_flush),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    assign mem_we     = pk_word_valid;
    assign mem_addr   = addr_q;
    assign mem_wdata  = pk_word;
    assign core_run   = (state_q == RUN);
    assign core_clear = core_clear_c;
    assign byte_count = count_q;
    assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a short timeout
// so the gap-timeout path can be exercised quickly.
module tb_program_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 200;

    logic              clk;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              start_req;
    logic              abort;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_run;
    logic              core_clear;
    logic [15:0]       byte_count;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    program_loader #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .start_req  (start_req),
        .abort      (abort),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_run   (core_run),
        .core_clear (core_clear),
        .byte_count (byte_count),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory writes are logged mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(mem_wdata);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic pulseStart();
        start_req = 1'b1;
        tick(1);
        start_req = 1'b0;
        tick(1);
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_ready  = 1'b1;
        rx_data   = 8'h01;
        start_req = 1'b0;
        abort     = 1'b0;

        // Reset values, with rx_ready held high across release.
        tick(2);
        @(negedge clk);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_core_run", 32'(core_run), 32'd0);
        checkOutput("reset_core_clear", 32'(core_clear), 32'd0);
        checkOutput("reset_byte_count", 32'(byte_count), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        rx_ready = 1'b0;
        tick(2);
        clearLog();
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        tick(3);
        checkOutput("held_ready_error", 32'(error), 32'd0);
        checkOutput("held_ready_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            checkOutput("held_ready_addr", wr_addr[0], 32'd0);
            checkOutput("held_ready_data", wr_data[0], 32'h0000CDAB);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);

        // Full words followed by start.
        clearLog();
        applyStimulus(8'h08);
        applyStimulus(8'h00);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
        applyStimulus(8'h55); applyStimulus(8'h66); applyStimulus(8'h77); applyStimulus(8'h88);
        tick(3);
        checkOutput("full_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            checkOutput("full_addr0", wr_addr[0], 32'd0);
            checkOutput("full_data0", wr_data[0], 32'h44332211);
            checkOutput("full_addr1", wr_addr[1], 32'd1);
            checkOutput("full_data1", wr_data[1], 32'h88776655);
        end
        checkOutput("full_byte_count", 32'(byte_count), 32'd8);
        checkOutput("full_run_before", 32'(core_run), 32'd0);
        start_req = 1'b1;
        @(negedge clk);
        checkOutput("start_clear_pulse", 32'(core_clear), 32'd1);
        checkOutput("start_run_not_yet", 32'(core_run), 32'd0);
        tick(1);
        @(negedge clk);
        checkOutput("start_clear_done", 32'(core_clear), 32'd0);
        checkOutput("start_run", 32'(core_run), 32'd1);
        start_req = 1'b0;
        tick(2);

        // Abort while running.
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_run_same_cycle", 32'(core_run), 32'd1);
        tick(1);
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_run_next", 32'(core_run), 32'd0);
        checkOutput("abort_count", 32'(byte_count), 32'd0);
        tick(1);

        // Partial last word flushed with zero padding.
        clearLog();
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC);
        applyStimulus(8'hDD); applyStimulus(8'hEE);
        tick(3);
        checkOutput("part_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            checkOutput("part_addr0", wr_addr[0], 32'd0);
            checkOutput("part_data0", wr_data[0], 32'hDDCCBBAA);
            checkOutput("part_addr1", wr_addr[1], 32'd1);
            checkOutput("part_data1", wr_data[1], 32'h000000EE);
        end
        checkOutput("part_byte_count", 32'(byte_count), 32'd5);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);

        // Zero length is rejected.
        clearLog();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        tick(1);
        checkOutput("len0_error", 32'(error), 32'd1);
        checkOutput("len0_nwr", 32'(wr_addr.size()), 32'd0);
        pulseStart();
        checkOutput("len0_cleared", 32'(error), 32'd0);

        // Length one past capacity is rejected.
        applyStimulus(8'h01);
        applyStimulus(8'h04);
        tick(1);
        checkOutput("len1025_error", 32'(error), 32'd1);
        pulseStart();
        checkOutput("len1025_cleared", 32'(error), 32'd0);

        // Length exactly at capacity is accepted.
        applyStimulus(8'h00);
        applyStimulus(8'h04);
        tick(2);
        checkOutput("len1024_ok", 32'(error), 32'd0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);

        // Gap timeout inside the payload.
        clearLog();
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        tick(150);
        checkOutput("timeout_early", 32'(error), 32'd0);
        tick(100);
        checkOutput("timeout_error", 32'(error), 32'd1);
        applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
        tick(2);
        checkOutput("timeout_ignored_nwr", 32'(wr_addr.size()), 32'd0);
        checkOutput("timeout_ignored_count", 32'(byte_count), 32'd1);
        pulseStart();

        // Abort coinciding with a lane-3 byte event.
        clearLog();
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        rx_data  = 8'h44;
        rx_ready = 1'b1;
        abort    = 1'b1;
        tick(1);
        abort    = 1'b0;
        rx_ready = 1'b0;
        @(negedge clk);
        checkOutput("abort_byte_we", 32'(mem_we), 32'd0);
        checkOutput("abort_byte_count", 32'(byte_count), 32'd0);
        tick(2);
        checkOutput("abort_byte_nwr", 32'(wr_addr.size()), 32'd0);
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
        tick(2);
        checkOutput("after_abort_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            checkOutput("after_abort_data", wr_data[0], 32'h04030201);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);

        // Asynchronous reset in the middle of a write cycle.
        applyStimulus(8'h06);
        applyStimulus(8'h00);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        rx_data  = 8'h44;
        rx_ready = 1'b1;
        tick(1);
        checkOutput("pre_reset_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #2;
        checkOutput("async_reset_we", 32'(mem_we), 32'd0);
        checkOutput("async_reset_count", 32'(byte_count), 32'd0);
        checkOutput("async_reset_error", 32'(error), 32'd0);
        rx_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
